// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parametrised register file.
package reg_file_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: array select, optional write bypass, zero forcing.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [(DATA_W<<ADDR_W)-1:0]   regs_flat,
  input  logic [ADDR_W-1:0]             adr,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_adr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          force_zero,
  output logic [DATA_W-1:0]             data
);

  logic [DATA_W-1:0] data_nxt;

  // Priority: sweep/zero-reg forcing beats bypass beats the stored value.
  always_comb begin
    data_nxt = regs_flat[int'(adr)*DATA_W +: DATA_W];
    if (BYPASS != 0 && wr_en && wr_adr == adr)
      data_nxt = wr_data;
    if (ZERO_REG != 0 && adr == '0)
      data_nxt = '0;
    if (force_zero)
      data_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      data <= '0;
    else
      data <= data_nxt;
  end

endmodule

// File: rtl/reg_file_param.sv
// Register array with one write port, two read ports and a bulk-clear sweep.
// state | meaning
// IDLE  | normal reads/writes; clr starts a sweep
// CLEAR | zero reg[cnt] each cycle, writes dropped, reads return 0
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] W_Adr,
  input  logic [DATA_W-1:0] W,
  input  logic [ADDR_W-1:0] R_Adr,
  input  logic [ADDR_W-1:0] S_Adr,
  input  logic              clr,
  output logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] S,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2**ADDR_W;

  state_t                      state, state_nxt;
  logic [ADDR_W-1:0]           cnt;
  logic [DATA_W-1:0]           mem [DEPTH];
  logic [(DATA_W<<ADDR_W)-1:0] regs_flat;
  logic                        wr_ok;
  logic                        drop_nxt;
  logic                        read_zero;

  always_comb begin
    state_nxt = state;
    wr_ok     = 1'b0;
    drop_nxt  = 1'b0;
    read_zero = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          read_zero = 1'b1;
          drop_nxt  = we;
        end else begin
          // Writes to a hardwired-zero register vanish without a drop pulse.
          wr_ok = we && !(ZERO_REG != 0 && W_Adr == '0);
        end
      end
      CLEAR: begin
        read_zero = 1'b1;
        drop_nxt  = we;
        if (cnt == '1)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_drop <= drop_nxt;
      if (state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[W_Adr] <= W;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = mem[g];
  end

  assign busy = (state == CLEAR);

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_r (
    .clk(clk), .reset_n(reset_n), .regs_flat(regs_flat), .adr(R_Adr),
    .wr_en(wr_ok), .wr_adr(W_Adr), .wr_data(W), .force_zero(read_zero),
    .data(R)
  );

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_s (
    .clk(clk), .reset_n(reset_n), .regs_flat(regs_flat), .adr(S_Adr),
    .wr_en(wr_ok), .wr_adr(W_Adr), .wr_data(W), .force_zero(read_zero),
    .data(S)
  );

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench: three configurations (bypass, no bypass, zero-reg) share one stimulus.
module tb_reg_file_param;

  localparam int SIG_R = 0, SIG_S = 1, SIG_BUSY = 2, SIG_DROP = 3;
  localparam int D_BYP = 0, D_NOBYP = 1, D_ZERO = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we, clr;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic [15:0] W;
  logic [15:0] r_o [3];
  logic [15:0] s_o [3];
  logic        busy_o [3];
  logic        drop_o [3];

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_byp (
    .clk(clk), .reset_n(reset_n), .we(we), .W_Adr(W_Adr), .W(W), .R_Adr(R_Adr),
    .S_Adr(S_Adr), .clr(clr), .R(r_o[0]), .S(s_o[0]), .busy(busy_o[0]),
    .wr_drop(drop_o[0]));

  reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_nobyp (
    .clk(clk), .reset_n(reset_n), .we(we), .W_Adr(W_Adr), .W(W), .R_Adr(R_Adr),
    .S_Adr(S_Adr), .clr(clr), .R(r_o[1]), .S(s_o[1]), .busy(busy_o[1]),
    .wr_drop(drop_o[1]));

  reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_zero (
    .clk(clk), .reset_n(reset_n), .we(we), .W_Adr(W_Adr), .W(W), .R_Adr(R_Adr),
    .S_Adr(S_Adr), .clr(clr), .R(r_o[2]), .S(s_o[2]), .busy(busy_o[2]),
    .wr_drop(drop_o[2]));

  typedef struct {
    int          due;
    int          dut;
    int          sig;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(int dut, int sig);
    case (sig)
      SIG_R:    return r_o[dut];
      SIG_S:    return s_o[dut];
      SIG_BUSY: return {15'b0, busy_o[dut]};
      default:  return {15'b0, drop_o[dut]};
    endcase
  endfunction

  // Expectation applies to outputs after the next rising edge.
  task automatic exp_chk(int dut, int sig, logic [15:0] val, string name);
    q.push_back('{cyc + 1, dut, sig, val, name});
  endtask

  task automatic set_in(logic w_e, logic [2:0] wa, logic [15:0] wd,
                        logic [2:0] ra, logic [2:0] sa, logic c);
    @(negedge clk);
    we = w_e; W_Adr = wa; W = wd; R_Adr = ra; S_Adr = sa; clr = c;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        a = actual(e.dut, e.sig);
        checks++;
        if (e.due != cyc || a !== e.val) begin
          failures++;
          $display("FAIL %s dut%0d: got %h want %h (cycle %0d due %0d)",
                   e.name, e.dut, a, e.val, cyc, e.due);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] v;
    reset_n = 1'b0;
    we = 0; clr = 0; W_Adr = 0; W = 0; R_Adr = 0; S_Adr = 0;

    // Reset state
    set_in(0, 0, 0, 0, 7, 0);
    exp_chk(D_BYP, SIG_R, 16'h0, "rst_R");
    exp_chk(D_BYP, SIG_S, 16'h0, "rst_S");
    exp_chk(D_BYP, SIG_BUSY, 16'h0, "rst_busy");
    exp_chk(D_BYP, SIG_DROP, 16'h0, "rst_drop");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 3'(i), 3'(7 - i), 0);
      exp_chk(D_BYP, SIG_R, 16'h0, "init_R");
      exp_chk(D_BYP, SIG_S, 16'h0, "init_S");
    end

    for (int i = 0; i < 8; i++) begin
      set_in(1, 3'(i), 16'hFFFF - 16'(i), 0, 0, 0);
      if (i == 0) exp_chk(D_ZERO, SIG_DROP, 16'h0, "zero_wr_nodrop_fill");
    end

    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 3'(i), 3'(7 - i), 0);
      exp_chk(D_BYP, SIG_R, 16'hFFFF - 16'(i), "rb_R");
      exp_chk(D_BYP, SIG_S, 16'hFFFF - 16'(7 - i), "rb_S");
      if (i == 0) exp_chk(D_ZERO, SIG_R, 16'h0, "zero_rb_R0");
      if (i == 7) exp_chk(D_ZERO, SIG_S, 16'h0, "zero_rb_S0");
    end

    // Same-edge write/read
    set_in(1, 3, 16'hBEEF, 3, 4, 0);
    exp_chk(D_BYP,   SIG_R, 16'hBEEF, "bypass_R");
    exp_chk(D_BYP,   SIG_S, 16'hFFFB, "bypass_S_other");
    exp_chk(D_NOBYP, SIG_R, 16'hFFFC, "nobypass_old");
    set_in(0, 0, 0, 3, 3, 0);
    exp_chk(D_NOBYP, SIG_R, 16'hBEEF, "nobypass_after");
    exp_chk(D_NOBYP, SIG_S, 16'hBEEF, "same_adr_S");

    // Hardwired zero register
    set_in(1, 0, 16'h1234, 0, 0, 0);
    exp_chk(D_ZERO, SIG_R, 16'h0, "zero_wr_R");
    exp_chk(D_ZERO, SIG_DROP, 16'h0, "zero_wr_nodrop");
    exp_chk(D_BYP,  SIG_R, 16'h1234, "bypass_R0");
    set_in(0, 0, 0, 0, 0, 0);
    exp_chk(D_ZERO, SIG_R, 16'h0, "zero_after_R");
    exp_chk(D_BYP,  SIG_R, 16'h1234, "reg0_after_R");

    for (int i = 0; i < 8; i++)
      set_in(1, 3'(i), 16'hA5A5, 0, 0, 0);
    set_in(0, 0, 0, 2, 5, 0);
    exp_chk(D_BYP, SIG_R, 16'hA5A5, "fill_R");

    // Sweep: j = edges after the clr edge
    for (int j = 0; j <= 8; j++) begin
      if (j == 0)      set_in(1, 5, 16'h7777, 2, 5, 1);
      else if (j == 2) set_in(1, 2, 16'h1111, 2, 5, 0);
      else if (j == 4) set_in(0, 0, 0, 2, 5, 1);
      else             set_in(0, 0, 0, 2, 5, 0);
      exp_chk(D_BYP, SIG_BUSY, (j < 8) ? 16'h1 : 16'h0, "sweep_busy");
      exp_chk(D_BYP, SIG_DROP, (j == 0 || j == 2) ? 16'h1 : 16'h0, "sweep_drop");
      exp_chk(D_BYP, SIG_R, 16'h0, "sweep_R");
    end
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 3'(i), 3'(7 - i), 0);
      exp_chk(D_BYP, SIG_R, 16'h0, "cleared_R");
      exp_chk(D_BYP, SIG_S, 16'h0, "cleared_S");
    end

    // Reset in the middle of a sweep
    set_in(1, 6, 16'h7777, 0, 0, 0);
    set_in(0, 0, 0, 6, 7, 1);
    for (int j = 1; j < 4; j++) begin
      set_in(0, 0, 0, 6, 7, 0);
      exp_chk(D_BYP, SIG_BUSY, 16'h1, "pre_rst_busy");
    end
    set_in(1, 6, 16'h5555, 7, 7, 0);
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    exp_chk(D_BYP, SIG_BUSY, 16'h0, "midrst_busy");
    exp_chk(D_BYP, SIG_R, 16'h0, "midrst_R");
    exp_chk(D_BYP, SIG_DROP, 16'h0, "midrst_drop");
    set_in(0, 0, 0, 6, 7, 0);
    v = 16'h5555;
    exp_chk(D_BYP, SIG_R, v, "post_rst_wr");
    exp_chk(D_BYP, SIG_S, 16'h0, "post_rst_reg7");

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
